month_year_counter: RTL and testbench
=====================================

# month_year_counter

Calendar stage directly downstream of the day counter in the millennium clock. Consumes the day-wrap carry, advances month and year, and supplies the day counter's `current_month` and `is_leap_year` inputs. Supports manual set of month or year with inc/dec while `ctrl_set` is high. Covers years 2000–2999 and flags a millennium wrap.

## Interface
Parameters:
- `RESET_MONTH`, default 1: month loaded on reset (1–12).
- `RESET_YEAR`, default 2000: year loaded on reset (2000–2999).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `inc`  in  1  set-mode increment strobe, one cycle.
- `dec`  in  1  set-mode decrement strobe, one cycle.
- `ctrl_set`  in  1  set mode enable.
- `sel_year`  in  1  set-mode field select: 0 = month, 1 = year.
- `carry_in_day`  in  1  one-cycle pulse from the day counter on the last day of the month.
- `current_month`  out  4  month 1–12, registered.
- `year`  out  12  binary year 2000–2999, registered.
- `is_leap_year`  out  1  leap flag for `year`, combinational from registers.
- `days_in_month`  out  6  28/29/30/31 for the current month and year, combinational.
- `carry_out`  out  1  millennium wrap pulse, combinational.

## Operation
- Reset: `current_month` = `RESET_MONTH`, `year` = `RESET_YEAR`. With defaults: `is_leap_year` = 1, `days_in_month` = 31, `carry_out` = 0.
- Internal state is held as `century` (20–29) and `yic`, year-in-century (0–99). `year` = century*100 + yic.
- Leap rule: `yic[1:0]==0 && (yic!=0 || century[1:0]==0)`. So 2000, 2400 and 2800 are leap years; 2100, 2200, 2300 and 2900 are not.
- Normal mode (`ctrl_set`=0), on `carry_in_day`:
  - Month 1–11: month+1.
  - Month 12: month←1 and year+1.
  - Year increment: yic 99→0 with century+1. Century 29 with yic 99 wraps to 2000.
- Set mode (`ctrl_set`=1):
  - `carry_in_day` is ignored.
  - `inc` has priority over `dec`.
  - Month field: inc 12→1, dec 1→12. The year does not change.
  - Year field: inc 2999→2000, dec 2000→2999, with the same yic/century borrow/carry rules.
  - The month is never changed by a year edit.
- `carry_out` = `carry_in_day && !ctrl_set && month==12 && year==2999`.
- `days_in_month`: Feb gives 29 if leap, else 28. Apr, Jun, Sep and Nov give 30. All others give 31.
- Out-of-range register values (from a parameter misuse) recover as follows:
  - Month 0 or 13–15: next increment loads 1.
  - yic > 99 is treated as 99 on increment.

## Timing
- `current_month` and `year` update on the rising edge where `carry_in_day` or a strobe is sampled. Latency is 1 cycle.
- `is_leap_year` and `days_in_month` follow registered state in the same cycle, with no extra latency. The day counter sees new month limits on the cycle after the carry.
- `carry_out` is valid in the cycle of `carry_in_day`, before the wrap edge.
- `ctrl_set` falling in the same cycle as a carry: the carry is applied, because the condition is evaluated on sampled values.
- Asynchronous reset mid-operation loads reset values immediately. The first post-reset edge behaves normally.
- Back-to-back carries on consecutive cycles each advance one month.

## Structure
- Shared package `clock_pkg` holds:
  - month constants `JAN`..`DEC`
  - `YEAR_MIN`=2000 and `YEAR_MAX`=2999
  - `CENTURY_MIN`=20 and `CENTURY_MAX`=29
  - function `days_in_month_f(month, leap)`, also reused by the day counter's future refactor.
- One sub-module: `leap_year_detect`, with inputs `century`[4:0] and `yic`[6:0] and output `leap`. It is purely combinational and unit-tested separately.
- Binary-to-display conversion of `year` is out of scope here.

## Test plan
- Reset with defaults: month=1, year=2000, `is_leap_year`=1, `days_in_month`=31, `carry_out`=0.
- Set Feb 2100 via set mode, release `ctrl_set`:
  - `is_leap_year`=0, `days_in_month`=28.
  - Set 2400: leap=1, days=29.
- Month 12, year 2023, pulse `carry_in_day` → next cycle month=1, year=2024, leap=1, `carry_out`=0 throughout.
- Month 12, year 2999, pulse `carry_in_day` → `carry_out`=1 in that cycle; next cycle month=1, year=2000.
- Set mode:
  - Month field: dec at month 1 → 12, year unchanged.
  - Year field: dec at 2000 → 2999.
  - `inc` and `dec` together at 2099 → 2100.
  - `carry_in_day` during set mode: no change.
- Assert `rst_n` low mid-count at month 7, year 2555 → outputs return to 1/2000 without a clock edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared calendar constants and helpers for the millennium clock stages.
package clock_pkg;

  localparam logic [3:0] JAN = 4'd1;
  localparam logic [3:0] FEB = 4'd2;
  localparam logic [3:0] MAR = 4'd3;
  localparam logic [3:0] APR = 4'd4;
  localparam logic [3:0] MAY = 4'd5;
  localparam logic [3:0] JUN = 4'd6;
  localparam logic [3:0] JUL = 4'd7;
  localparam logic [3:0] AUG = 4'd8;
  localparam logic [3:0] SEP = 4'd9;
  localparam logic [3:0] OCT = 4'd10;
  localparam logic [3:0] NOV = 4'd11;
  localparam logic [3:0] DEC = 4'd12;

  localparam logic [11:0] YEAR_MIN    = 12'd2000;
  localparam logic [11:0] YEAR_MAX    = 12'd2999;
  localparam logic [4:0]  CENTURY_MIN = 5'd20;
  localparam logic [4:0]  CENTURY_MAX = 5'd29;
  localparam logic [6:0]  YIC_MAX     = 7'd99;

  // Month length in days; out-of-range month codes fall into the 31-day group.
  function automatic logic [5:0] days_in_month_f(input logic [3:0] month, input logic leap);
    logic [5:0] days;
    case (month)
      FEB:               days = leap ? 6'd29 : 6'd28;
      APR, JUN, SEP, NOV: days = 6'd30;
      default:           days = 6'd31;
    endcase
    return days;
  endfunction

endpackage

// File: rtl/leap_year_detect.sv
// Gregorian leap detection on the split century / year-in-century form.
module leap_year_detect (
  input  logic [4:0] century,
  input  logic [6:0] yic,
  output logic       leap
);

  // Every fourth year is leap, except century years whose century is not a multiple of 4.
  assign leap = ((yic % 7'd4) == 7'd0) && ((yic != 7'd0) || ((century % 5'd4) == 5'd0));

endmodule

// File: rtl/month_year_counter.sv
// Month and year stage of the millennium clock: advances on the day-wrap
// carry, supports manual month/year editing, and flags the 2999->2000 wrap.
module month_year_counter
  import clock_pkg::*;
#(
  parameter int RESET_MONTH = 1,
  parameter int RESET_YEAR  = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        dec,
  input  logic        ctrl_set,
  input  logic        sel_year,
  input  logic        carry_in_day,
  output logic [3:0]  current_month,
  output logic [11:0] year,
  output logic        is_leap_year,
  output logic [5:0]  days_in_month,
  output logic        carry_out
);

  localparam logic [3:0] RESET_MONTH_V   = 4'(RESET_MONTH);
  localparam logic [4:0] RESET_CENTURY_V = 5'(RESET_YEAR / 100);
  localparam logic [6:0] RESET_YIC_V     = 7'(RESET_YEAR % 100);

  logic [3:0] month_reg, month_next;
  logic [4:0] century_reg, century_next;
  logic [6:0] yic_reg, yic_next;

  // One-step neighbours of the current state; out-of-range codes recover here.
  logic [3:0] month_up, month_dn;
  logic [4:0] century_up, century_dn;
  logic [6:0] yic_up, yic_dn;

  assign month_up = ((month_reg >= DEC) || (month_reg == 4'd0)) ? JAN : month_reg + 4'd1;
  assign month_dn = ((month_reg <= JAN) || (month_reg > DEC)) ? DEC : month_reg - 4'd1;

  // yic above 99 behaves as 99, so an increment rolls into the next century.
  assign yic_up     = (yic_reg >= YIC_MAX) ? 7'd0 : yic_reg + 7'd1;
  assign century_up = (yic_reg >= YIC_MAX)
                    ? ((century_reg >= CENTURY_MAX) ? CENTURY_MIN : century_reg + 5'd1)
                    : century_reg;

  assign yic_dn     = (yic_reg == 7'd0) ? YIC_MAX
                    : ((yic_reg > YIC_MAX) ? YIC_MAX - 7'd1 : yic_reg - 7'd1);
  assign century_dn = (yic_reg == 7'd0)
                    ? ((century_reg <= CENTURY_MIN) ? CENTURY_MAX : century_reg - 5'd1)
                    : century_reg;

  // Next-state selection: set mode edits one field, otherwise the day carry advances the calendar.
  always_comb begin
    month_next   = month_reg;
    century_next = century_reg;
    yic_next     = yic_reg;
    if (ctrl_set) begin
      if (inc) begin
        if (sel_year) begin
          century_next = century_up;
          yic_next     = yic_up;
        end else begin
          month_next = month_up;
        end
      end else if (dec) begin
        if (sel_year) begin
          century_next = century_dn;
          yic_next     = yic_dn;
        end else begin
          month_next = month_dn;
        end
      end
    end else if (carry_in_day) begin
      month_next = month_up;
      if (month_reg == DEC) begin
        century_next = century_up;
        yic_next     = yic_up;
      end
    end
  end

  // Calendar state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      month_reg   <= RESET_MONTH_V;
      century_reg <= RESET_CENTURY_V;
      yic_reg     <= RESET_YIC_V;
    end else begin
      month_reg   <= month_next;
      century_reg <= century_next;
      yic_reg     <= yic_next;
    end
  end

  leap_year_detect u_leap (
    .century (century_reg),
    .yic     (yic_reg),
    .leap    (is_leap_year)
  );

  assign current_month = month_reg;
  assign year          = 12'(century_reg) * 12'd100 + 12'(yic_reg);
  assign days_in_month = days_in_month_f(month_reg, is_leap_year);

  // Wrap pulse is visible during the carry cycle, before the edge that rolls the year over.
  assign carry_out = carry_in_day && !ctrl_set && (month_reg == DEC) && (year == YEAR_MAX);

endmodule

// File: tb/tb_month_year_counter.sv
// Self-checking bench: directed calendar scenarios plus random traffic,
// compared against a plain-arithmetic calendar model.
module tb_month_year_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inc = 1'b0;
  logic        dec = 1'b0;
  logic        ctrl_set = 1'b0;
  logic        sel_year = 1'b0;
  logic        carry_in_day = 1'b0;
  logic [3:0]  current_month;
  logic [11:0] year;
  logic        is_leap_year;
  logic [5:0]  days_in_month;
  logic        carry_out;

  int errors = 0;
  int checks = 0;
  int txn = 0;
  int m_month = 1;
  int m_year = 2000;

  always #5 clk = ~clk;

  month_year_counter #(
    .RESET_MONTH (1),
    .RESET_YEAR  (2000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inc           (inc),
    .dec           (dec),
    .ctrl_set      (ctrl_set),
    .sel_year      (sel_year),
    .carry_in_day  (carry_in_day),
    .current_month (current_month),
    .year          (year),
    .is_leap_year  (is_leap_year),
    .days_in_month (days_in_month),
    .carry_out     (carry_out)
  );

  function automatic int ref_leap(input int y);
    return ((y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0))) ? 1 : 0;
  endfunction

  function automatic int ref_days(input int m, input int y);
    int table_days[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2) return 28 + ref_leap(y);
    return table_days[m - 1];
  endfunction

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed=%0d expected=%0d (model %0d/%0d)", tag, observed, expected,
               m_month, m_year);
    end
  endtask

  task automatic check_state();
    check("month", int'(current_month), m_month);
    check("year", int'(year), m_year);
    check("leap", int'(is_leap_year), ref_leap(m_year));
    check("days", int'(days_in_month), ref_days(m_month, m_year));
  endtask

  // Called at posedge+1: drive, check at negedge, advance the model, return at next posedge+1.
  task automatic step(input bit i_inc, input bit i_dec, input bit i_set, input bit i_sel,
                      input bit i_carry);
    int exp_co;
    int delta;
    int idx;
    inc = i_inc;
    dec = i_dec;
    ctrl_set = i_set;
    sel_year = i_sel;
    carry_in_day = i_carry;
    @(negedge clk);
    exp_co = (i_carry && !i_set && m_month == 12 && m_year == 2999) ? 1 : 0;
    check_state();
    check("carry_out", int'(carry_out), exp_co);
    txn++;
    $display("txn %0d set=%0b sel=%0b inc=%0b dec=%0b carry=%0b : month=%0d year=%0d co=%0b",
             txn, i_set, i_sel, i_inc, i_dec, i_carry, current_month, year, carry_out);
    if (i_set) begin
      delta = i_inc ? 1 : (i_dec ? -1 : 0);
      if (i_sel) m_year = 2000 + ((m_year - 2000 + delta + 1000) % 1000);
      else       m_month = 1 + ((m_month - 1 + delta + 12) % 12);
    end else if (i_carry) begin
      idx = m_year * 12 + (m_month - 1) + 1;
      m_month = idx % 12 + 1;
      m_year = idx / 12;
      if (m_year > 2999) m_year = 2000;
    end
    @(posedge clk);
    #1;
  endtask

  // Walk to a target date through set mode, then release set mode.
  task automatic goto_date(input int tm, input int ty);
    while (m_month != tm) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    while (m_year != ty) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    check_state();
    check("reset_carry_out", int'(carry_out), 0);
    rst_n = 1'b1;

    // Feb 2100 is not leap, Feb 2400 is
    goto_date(2, 2100);
    check("feb2100_days", int'(days_in_month), 28);
    goto_date(2, 2400);
    check("feb2400_days", int'(days_in_month), 29);

    // Year rollover on December carry
    goto_date(12, 2023);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Millennium wrap
    goto_date(12, 2999);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Set-mode boundaries
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    goto_date(3, 2099);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    // Carry while set mode drops is applied; back-to-back carries
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-operation, no clock edge involved
    goto_date(7, 2555);
    rst_n = 1'b0;
    #2;
    m_month = 1;
    m_year = 2000;
    check_state();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
           ($urandom % 2) == 0, ($urandom % 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
